// File: rtl/game_pkg.sv
// game_pkg: shared present types, screen constants and present FSM states
package game_pkg;
    typedef enum logic [1:0] {
        PRES_LIFE     = 2'b00,
        PRES_ROPE     = 2'b01,
        PRES_SPEED    = 2'b10,
        PRES_IMMORTAL = 2'b11
    } present_type_t;
    typedef enum logic [1:0] {IDLE, FALLING, LANDED} pres_state_t;
    localparam int X_MAX   = 639;
    localparam int FLOOR_Y = 440;
    function automatic logic [10:0] min11(input logic [10:0] a, input logic [10:0] b);
        return (a < b) ? a : b;
    endfunction
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) with seed and step enable
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       en,
    output logic [7:0] q
);
    // shift left, feedback from taps 8,6,5,4 into bit 0
    always_ff @(posedge clk)
        if (resetN) q <= SEED;
        else if (en) q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
endmodule

// File: rtl/present_controller.sv
// present_controller: spawns, drops, rests and removes the single bonus present; PRESENT_BLINK_EN blinks it near despawn
module present_controller #(
    parameter int         FALL_SPEED      = 2,
    parameter int         FLOOR_Y         = game_pkg::FLOOR_Y,
    parameter int         LIFETIME_FRAMES = 300,
    parameter int         PRESENT_W       = 32,
    parameter int         X_MAX           = game_pkg::X_MAX,
`ifdef PRESENT_BLINK_EN
    parameter int         BLINK_FRAMES    = 90,
`endif
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        presentsVisible,
    input  logic        presentDrop,
    input  logic [10:0] dropX,
    input  logic [10:0] dropY,
    input  logic        col_present,
    output logic [1:0]  presentChance,
    output logic [1:0]  presentType,
    output logic [10:0] presentX,
    output logic [10:0] presentY,
    output logic        presentActive,
    output logic        presentShow
);
    import game_pkg::*;
    localparam int LW = $clog2(LIFETIME_FRAMES);
    logic [7:0]    lfsr;
    logic [LW-1:0] life_cnt;
    logic [10:0]   next_y;
    pres_state_t   state;
    present_type_t pres_type;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .resetN(resetN), .en(1'b1), .q(lfsr));

    assign presentChance = lfsr[1:0];
    assign presentType   = pres_type;
    assign next_y        = presentY + 11'(FALL_SPEED);
`ifdef PRESENT_BLINK_EN
    assign presentShow = (state == LANDED && life_cnt < LW'(BLINK_FRAMES)) ? life_cnt[3] : presentActive;
`else
    assign presentShow = presentActive;
`endif

    // present lifecycle: abort and collection take priority over spawn, fall and lifetime updates
    always_ff @(posedge clk) begin
        if (resetN) begin
            state         <= IDLE;
            pres_type     <= PRES_LIFE;
            presentX      <= '0;
            presentY      <= '0;
            presentActive <= 1'b0;
            life_cnt      <= '0;
        end else if (!presentsVisible || (state != IDLE && col_present)) begin
            state         <= IDLE;
            presentActive <= 1'b0;
        end else begin
            case (state)
                IDLE: if (presentDrop && !col_present) begin
                    state         <= FALLING;
                    pres_type     <= present_type_t'(lfsr[3:2]);
                    presentX      <= min11(dropX, 11'(X_MAX - PRESENT_W + 1));
                    presentY      <= min11(dropY, 11'(FLOOR_Y));
                    presentActive <= 1'b1;
                end
                FALLING: if (startOfFrame) begin
                    presentY <= min11(next_y, 11'(FLOOR_Y));
                    if (next_y >= 11'(FLOOR_Y)) begin
                        state    <= LANDED;
                        life_cnt <= LW'(LIFETIME_FRAMES - 1);
                    end
                end
                LANDED: if (startOfFrame) begin
                    if (life_cnt == '0) begin
                        state         <= IDLE;
                        presentActive <= 1'b0;
                    end else begin
                        life_cnt <= life_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_present_controller.sv
// tb_present_controller: directed and random checks of present_controller against a behavioural model
module tb_present_controller;
    logic        clk = 0, resetN = 1, sof = 0, vis = 0, drop = 0, col = 0;
    logic [10:0] dx = 0, dy = 0;
    logic [1:0]  chance, ptype;
    logic [10:0] px, py;
    logic        pact, pshow;
    int          n_cmp = 0, n_err = 0;
    logic [7:0]  m_lfsr;
    logic [1:0]  m_type;
    bit          m_act, m_land;
    int          m_x, m_y, m_life;
    logic [1:0]  t;
`ifdef PRESENT_BLINK_EN
    localparam bit BLINK = 1;
`else
    localparam bit BLINK = 0;
`endif

    present_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .presentsVisible(vis),
        .presentDrop(drop), .dropX(dx), .dropY(dy), .col_present(col),
        .presentChance(chance), .presentType(ptype), .presentX(px), .presentY(py),
        .presentActive(pact), .presentShow(pshow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic tick();
        sof = 1;
        cyc();
        sof = 0;
        cyc();
    endtask

    // model advances on each edge from the inputs it saw, then outputs are compared just after
    always @(posedge clk) begin
        if (resetN) begin
            m_lfsr = 8'hA5; m_act = 0; m_land = 0; m_type = 0; m_x = 0; m_y = 0; m_life = 0;
        end else begin
            if (!vis) m_act = 0;
            else if (m_act && col) m_act = 0;
            else if (!m_act) begin
                if (drop && !col) begin
                    m_act = 1; m_land = 0; m_type = m_lfsr[3:2];
                    m_x = (dx < 608) ? int'(dx) : 608;
                    m_y = (dy < 440) ? int'(dy) : 440;
                end
            end else if (!m_land) begin
                if (sof) begin
                    m_y = (m_y + 2 > 440) ? 440 : m_y + 2;
                    if (m_y == 440) begin m_land = 1; m_life = 299; end
                end
            end else if (sof) begin
                if (m_life == 0) m_act = 0;
                else m_life--;
            end
            m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        end
        #1;
        check("lfsr", dut.u_lfsr.q, m_lfsr);
        check("lfsr_nonzero", dut.u_lfsr.q != 0, 1);
        check("chance", chance, m_lfsr[1:0]);
        check("active", pact, m_act);
        check("show", pshow, (BLINK && m_act && m_land && m_life < 90) ? ((m_life >> 3) & 1) : m_act);
        if (m_act) begin
            check("type", ptype, m_type);
            check("x", px, m_x);
            check("y", py, m_y);
        end
    end

    initial begin
        repeat (3) cyc();
        resetN = 0;
        check("rst_chance", chance, 2'b01);
        check("rst_active", pact, 0);
        check("rst_show", pshow, 0);
        vis = 1;
        cyc();
        t = m_lfsr[3:2];
        drop = 1; dx = 100; dy = 200;
        cyc();
        drop = 0;
        check("spawn_x", px, 100);
        check("spawn_y", py, 200);
        check("spawn_active", pact, 1);
        check("spawn_type", ptype, t);
        repeat (119) tick();
        check("fall_119", py, 438);
        tick();
        check("fall_120", py, 440);
        repeat (299) tick();
        check("life_299", pact, 1);
        tick();
        check("despawn", pact, 0);
        t = m_lfsr[3:2];
        drop = 1; dx = 630; dy = 10;
        cyc();
        drop = 0;
        check("clamp_x", px, 608);
        check("type_lfsr", ptype, t);
        repeat (145) tick();
        check("y_300", py, 300);
        col = 1; drop = 1;
        check("col_type_hold", ptype, t);
        cyc();
        col = 0; drop = 0;
        check("col_active", pact, 0);
        cyc();
        check("col_drop_discard", pact, 0);
        drop = 1; dx = 300; dy = 500;
        cyc();
        drop = 0;
        check("floor_spawn_y", py, 440);
        tick();
        drop = 1; dx = 5; dy = 5;
        cyc();
        drop = 0;
        check("ignore_drop_x", px, 300);
        check("ignore_drop_y", py, 440);
        vis = 0;
        cyc();
        check("abort", pact, 0);
        vis = 1;
        drop = 1; dx = 50; dy = 600;
        cyc();
        drop = 0;
        tick();
        repeat (210) tick();
        check("show_life89", pshow, 1);
        repeat (2) tick();
        check("show_life87", pshow, BLINK ? 0 : 1);
        resetN = 1;
        cyc();
        resetN = 0;
        for (int i = 0; i < 4000; i++) begin
            sof  = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 15) == 0);
            col  = ($urandom_range(0, 40) == 0);
            vis  = ($urandom_range(0, 300) != 0);
            dx   = 11'($urandom_range(0, 800));
            dy   = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(430, 460)) : 11'($urandom_range(0, 600));
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/present_controller.md
Name: present_controller

Overview:
- Owns the single on-screen bonus present, directly feeding the game state machine.
- Supplies the per-hit drop chance (`presentChance`) from an internal LFSR, and spawns a present at the hit ball's position when `presentDrop` pulses.
- Drops the present under gravity each frame, holds it on the floor for a fixed lifetime, then removes it.
- Outputs the present's type and position to the game FSM and the present drawing/collision logic.

Parameters:
- FALL_SPEED, 2, pixels added to presentY per frame tick while falling
- FLOOR_Y, 440, top-edge Y at which the present lands (clamped)
- LIFETIME_FRAMES, 300, frames the present rests on the floor before despawn
- PRESENT_W, 32, present width in pixels
- X_MAX, 639, rightmost screen pixel
- LFSR_SEED, 8'hA5, LFSR reset value (non-zero)
- BLINK_FRAMES, 90, final lifetime frames that blink (only with PRESENT_BLINK_EN)

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous, active-high reset (asserted = 1)
- startOfFrame  in  1  one-cycle pulse per video frame
- presentsVisible  in  1  high while the game is in play mode; low forces the present away
- presentDrop  in  1  one-cycle spawn request
- dropX  in  11  ball X at the rope hit
- dropY  in  11  ball Y at the rope hit
- col_present  in  1  player/present collision pulse
- presentChance  out  2  current LFSR[1:0], combinational from the LFSR register
- presentType  out  2  type of the active present: 00 life, 01 super rope, 10 super speed, 11 immortal
- presentX  out  11  present top-left X
- presentY  out  11  present top-left Y
- presentActive  out  1  a present exists (falling or landed)
- presentShow  out  1  drawing enable

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - On reset: state IDLE; lfsr=LFSR_SEED; presentX=0; presentY=0; presentType=0; presentActive=0; presentShow=0; lifeCnt=0.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Steps every clk in all states, including IDLE; never reaches zero.
- State IDLE:
  - On presentDrop & presentsVisible & !col_present, go to FALLING next cycle.
  - presentType latched from lfsr[3:2] at the spawn cycle.
  - presentX = min(dropX, X_MAX-PRESENT_W+1).
  - presentY = min(dropY, FLOOR_Y).
  - presentActive=1 from the next cycle.
- State FALLING:
  - On each startOfFrame, presentY += FALL_SPEED, saturating at FLOOR_Y.
  - In the cycle presentY reaches FLOOR_Y, go to LANDED with lifeCnt=LIFETIME_FRAMES-1.
  - A spawn at dropY>=FLOOR_Y goes FALLING then LANDED on the first frame tick.
- State LANDED:
  - lifeCnt decrements on each startOfFrame.
  - A frame tick with lifeCnt==0 goes to IDLE.
- Collection:
  - col_present in FALLING or LANDED goes to IDLE next cycle.
  - presentType, presentX and presentY hold their values during the col_present cycle, so the game FSM samples the correct type.
  - presentActive=0 from the next cycle.
  - col_present in IDLE is ignored.
- Abort: presentsVisible low in any state goes to IDLE next cycle and clears presentActive. This covers game over and restart mid-fall.
- Simultaneous events:
  - presentDrop while FALLING or LANDED is ignored; there is only one present.
  - col_present and presentDrop in the same cycle: collection wins and the drop is discarded.
  - col_present and startOfFrame in the same cycle: collection wins, with no Y/lifeCnt update.
- presentShow = presentActive (without the optional feature).
- Arithmetic:
  - 11-bit unsigned, no wrap: FLOOR_Y+FALL_SPEED < 2048.
  - lifeCnt is $clog2(LIFETIME_FRAMES) bits wide.

Optional Feature:
- Macro: PRESENT_BLINK_EN.
- When defined: in LANDED with lifeCnt < BLINK_FRAMES, presentShow = lifeCnt[3] (toggles every 8 frames); otherwise presentShow = presentActive. Collision is unaffected by blinking.
- When undefined: presentShow = presentActive always, and BLINK_FRAMES is unused.

Decomposition:
- Shared package game_pkg holds:
  - present_type_t enum (PRES_LIFE=2'b00, PRES_ROPE, PRES_SPEED, PRES_IMMORTAL), also used by the game FSM;
  - screen constants X_MAX, FLOOR_Y;
  - state enum {IDLE, FALLING, LANDED}.
- Sub-module lfsr8 (seed parameter, step enable, 8-bit out), reusable for ball spawn randomness.

Test Plan:
- Reset with lfsr seed A5 → presentActive=0, presentShow=0, presentChance=A5[1:0]=01 in the first cycle after reset; LFSR never 0 over 300 cycles.
- presentDrop with dropX=100, dropY=200 → presentX=100, presentY=200; after 120 frame ticks presentY=440, state LANDED; despawn exactly 300 ticks later.
- presentDrop with dropX=630 → presentX=608; presentType equals the lfsr[3:2] value at the spawn cycle.
- col_present while falling at presentY=300 → presentType stable in that cycle; presentActive=0 the next cycle; a presentDrop in that same cycle creates no present.
- presentsVisible low while LANDED → IDLE next cycle; a presentDrop while active is ignored and position unchanged.
- With PRESENT_BLINK_EN: LANDED, lifeCnt 89..0 → presentShow follows lifeCnt[3]; without the macro, presentShow is constant 1.
